// File: rtl/mem_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

    // Grant identifiers: which requester owns the current transaction.
    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_DM = 1'b1;

    // Byte mask for a full-word access (instruction fetch).
    localparam logic [3:0] MASK_WORD = 4'b1111;

    // Memory is addressed in words; the byte offset is dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Priority select between fetch and data with a saturating starvation counter.
// Data wins by default; once STARVE_LIMIT consecutive data grants have been
// made while fetch was waiting, the next grant goes to fetch.
module arb_starve_ctr
    import mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 3,
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_if_req,
    input  logic             i_dm_req,
    input  logic             i_grant_en,
    output logic             o_win,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             if_wins;

    // Winner select and next count; the count only moves when a grant is made.
    always_comb begin
        if_wins = i_if_req && (!i_dm_req || (cnt_q == LIMIT));
        o_win   = if_wins ? GNT_IF : GNT_DM;
        cnt_d   = cnt_q;
        if (i_grant_en) begin
            if (o_win == GNT_IF) begin
                cnt_d = '0;
            end else if (i_if_req) begin
                cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + 1'b1;
            end else begin
                cnt_d = '0;
            end
        end
    end

    // Count register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port, variable-latency memory between the fetch and the
// data requesters, one transaction at a time.
//
// Handshake: a requester holds *_req (and its fields) until it sees *_ready,
// which is combinational and only asserts in IDLE; the request is accepted on
// that clock edge. Responses are one-cycle *_valid pulses. On the memory side
// o_mem_req and its fields stay stable until i_mem_ready; i_mem_valid is only
// looked at in REQ/WAIT.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 3,
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_if_req,
    input  logic [31:0]      i_if_addr,
    output logic             o_if_ready,
    output logic             o_if_valid,
    output logic [31:0]      o_if_rdata,
    input  logic             i_dm_req,
    input  logic [31:0]      i_dm_addr,
    input  logic             i_dm_wen,
    input  logic [31:0]      i_dm_wdata,
    input  logic [3:0]       i_dm_mask,
    output logic             o_dm_ready,
    output logic             o_dm_valid,
    output logic [31:0]      o_dm_rdata,
    output logic             o_mem_req,
    output logic [31:0]      o_mem_addr,
    output logic             o_mem_wen,
    output logic [31:0]      o_mem_wdata,
    output logic [3:0]       o_mem_mask,
    input  logic             i_mem_ready,
    input  logic             i_mem_valid,
    input  logic [31:0]      i_mem_rdata,
    output state_e           o_dbg_state,
    output logic [CNT_W-1:0] o_dbg_starve_cnt
);

    state_e      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic [31:0] addr_q, addr_d;
    logic        wen_q, wen_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] rdata_q, rdata_d;

    logic        grant_en;
    logic        win;

    arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_if_req   (i_if_req),
        .i_dm_req   (i_dm_req),
        .i_grant_en (grant_en),
        .o_win      (win),
        .o_cnt      (o_dbg_starve_cnt)
    );

    // Next-state, request latching and requester-side ready.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        addr_d     = addr_q;
        wen_d      = wen_q;
        wdata_d    = wdata_q;
        mask_d     = mask_q;
        rdata_d    = rdata_q;
        grant_en   = 1'b0;
        o_if_ready = 1'b0;
        o_dm_ready = 1'b0;
        case (state_q)
            IDLE: begin
                // Held off during reset so every output reads 0.
                if (!i_rst && (i_if_req || i_dm_req)) begin
                    grant_en = 1'b1;
                    gnt_d    = win;
                    state_d  = REQ;
                    if (win == GNT_IF) begin
                        o_if_ready = 1'b1;
                        addr_d     = i_if_addr;
                        wen_d      = 1'b0;
                        wdata_d    = 32'h0;
                        mask_d     = MASK_WORD;
                    end else begin
                        o_dm_ready = 1'b1;
                        addr_d     = i_dm_addr;
                        wen_d      = i_dm_wen;
                        wdata_d    = i_dm_wdata;
                        mask_d     = i_dm_mask;
                    end
                end
            end
            REQ: begin
                if (i_mem_ready) begin
                    if (i_mem_valid) begin
                        rdata_d = wen_q ? 32'h0 : i_mem_rdata;
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (i_mem_valid) begin
                    rdata_d = wen_q ? 32'h0 : i_mem_rdata;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched transaction registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            gnt_q   <= GNT_IF;
            addr_q  <= 32'h0;
            wen_q   <= 1'b0;
            wdata_q <= 32'h0;
            mask_q  <= 4'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
        end
    end

    // Response and memory-side outputs, derived only from registered state.
    always_comb begin
        o_if_valid  = (state_q == RESP) && (gnt_q == GNT_IF);
        o_dm_valid  = (state_q == RESP) && (gnt_q == GNT_DM);
        o_if_rdata  = o_if_valid ? rdata_q : 32'h0;
        o_dm_rdata  = o_dm_valid ? rdata_q : 32'h0;
        o_mem_req   = (state_q == REQ);
        o_mem_addr  = word_align(addr_q);
        o_mem_wen   = wen_q;
        o_mem_wdata = wdata_q;
        o_mem_mask  = mask_q;
        o_dbg_state = state_q;
    end

endmodule
